// File: rtl/pipelined_tree_hash.sv
// Pipelined XOR-fold hash: pads the key to a power-of-two number of OUT_WIDTH chunks,
// folds it one level per registered stage, then applies seed XOR and mask at the output.
module pipelined_tree_hash #(
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_RnnH,
  input  logic [OUT_WIDTH-1:0] mask_RnnH,
  input  logic [OUT_WIDTH-1:0] seed_RnnH,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_RnnH,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] hash_cnt
);

  localparam int NMIN   = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int L      = $clog2(NMIN);
  localparam int NCHUNK = 1 << L;
  localparam int PW     = NCHUNK * OUT_WIDTH;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage s holds NCHUNK>>s chunks; stage 0 is the padded key, stage L the final fold.
  for (genvar s = 0; s <= L; s++) begin : g_stg
    localparam int SW = (NCHUNK >> s) * OUT_WIDTH;

    logic                 vld_q, vld_d;
    logic [SW-1:0]        data_q, data_d;
    logic [OUT_WIDTH-1:0] mask_q, mask_d;
    logic [OUT_WIDTH-1:0] seed_q, seed_d;

    logic                 src_vld;
    logic [SW-1:0]        src_data;
    logic [OUT_WIDTH-1:0] src_mask;
    logic [OUT_WIDTH-1:0] src_seed;

    if (s == 0) begin : g_src
      assign src_vld  = in_valid;
      assign src_data = PW'(in_RnnH);
      assign src_mask = mask_RnnH;
      assign src_seed = seed_RnnH;
    end else begin : g_src
      // Low half XOR high half: chunk i ^ chunk i+n/2.
      assign src_vld  = g_stg[s-1].vld_q;
      assign src_data = g_stg[s-1].data_q[SW-1:0] ^ g_stg[s-1].data_q[2*SW-1:SW];
      assign src_mask = g_stg[s-1].mask_q;
      assign src_seed = g_stg[s-1].seed_q;
    end

    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      mask_d = mask_q;
      seed_d = seed_q;
      if (adv) begin
        vld_d = src_vld;
        if (src_vld) begin
          data_d = src_data;
          mask_d = src_mask;
          seed_d = src_seed;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      data_q <= data_d;
      mask_q <= mask_d;
      seed_q <= seed_d;
    end
  end

  // Output stage: gated by valid so the unreset datapath never leaks after reset.
  assign out_valid = g_stg[L].vld_q;
  assign out_RnnH  = out_valid ? ((g_stg[L].data_q ^ g_stg[L].seed_q) & g_stg[L].mask_q)
                               : '0;

  logic [CNT_WIDTH-1:0] hash_cnt_q, hash_cnt_d;

  always_comb begin
    hash_cnt_d = hash_cnt_q;
    if (cnt_clr)
      hash_cnt_d = '0;
    else if (out_valid && out_ready && !(&hash_cnt_q))
      hash_cnt_d = hash_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) hash_cnt_q <= '0;
    else     hash_cnt_q <= hash_cnt_d;
  end

  assign hash_cnt = hash_cnt_q;

endmodule

// File: tb/tb_pipelined_tree_hash.sv
// Directed bench for pipelined_tree_hash: a 40:8 instance for fold, flow control, reset and
// counter behaviour, plus a 20:8 instance with a 2-bit counter for the generic ratio.
module tb_pipelined_tree_hash;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cnt_clr;
  logic [39:0] in_key;
  logic [7:0]  mask, seed;
  logic        in_ready, out_valid;
  logic [7:0]  out_h;
  logic [15:0] hcnt;

  logic        g_in_valid, g_out_ready, g_cnt_clr;
  logic [19:0] g_key;
  logic [7:0]  g_mask, g_seed;
  logic        g_in_ready, g_out_valid;
  logic [7:0]  g_out_h;
  logic [1:0]  g_cnt;

  always #5 clk = ~clk;

  pipelined_tree_hash #(.IN_WIDTH(40), .OUT_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_RnnH(in_key),
    .mask_RnnH(mask), .seed_RnnH(seed), .out_valid(out_valid), .out_ready(out_ready),
    .out_RnnH(out_h), .cnt_clr(cnt_clr), .hash_cnt(hcnt)
  );

  pipelined_tree_hash #(.IN_WIDTH(20), .OUT_WIDTH(8), .CNT_WIDTH(2)) dut_g (
    .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready), .in_RnnH(g_key),
    .mask_RnnH(g_mask), .seed_RnnH(g_seed), .out_valid(g_out_valid), .out_ready(g_out_ready),
    .out_RnnH(g_out_h), .cnt_clr(g_cnt_clr), .hash_cnt(g_cnt)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic       acc;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [39:0] keys [8] = '{40'h0000000000, 40'hFFFFFFFFFF, 40'h8000000001, 40'h0123456789,
                            40'hDEADBEEF00, 40'h00000000FF, 40'hFF00000000, 40'h5A5A5A5A5A};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Flat XOR of the five key bytes, then seed and mask.
  function automatic logic [7:0] model(input logic [39:0] k, input logic [7:0] sd,
                                       input logic [7:0] mk);
    logic [7:0] f;
    f = 8'h00;
    for (int i = 0; i < 5; i++) f = f ^ k[i*8 +: 8];
    return (f ^ sd) & mk;
  endfunction

  // Settle inputs, note handshakes for this cycle, then advance one clock.
  task automatic cycle();
    #1;
    acc = in_valid & in_ready;
    if (out_valid && out_ready) got.push_back(out_h);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [39:0] k, input logic [7:0] sd, input logic [7:0] mk,
                         output logic [7:0] r);
    in_valid = 1'b1; in_key = k; seed = sd; mask = mk;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) cycle();
    chk("run_one_valid", out_valid, 1);
    r = out_h;
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, hold, k4exp;
    int n, prev, first, last;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_key = '0; mask = 8'hFF; seed = 8'h00;
    g_in_valid = 1'b0; g_out_ready = 1'b1; g_cnt_clr = 1'b0;
    g_key = '0; g_mask = 8'hFF; g_seed = 8'h00;
    cycle(); cycle();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_h", out_h, 0);
    chk("rst_hash_cnt", hcnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_g_out_valid", g_out_valid, 0);
    chk("rst_g_cnt", g_cnt, 0);

    // Basic fold with exact latency of 4
    got.delete();
    in_valid = 1'b1; in_key = 40'h0102030405; seed = 8'h00; mask = 8'hFF;
    cycle();
    chk("basic_accept", acc, 1);
    in_valid = 1'b0;
    cycle(); chk("basic_lat2", out_valid, 0);
    cycle(); chk("basic_lat3", out_valid, 0);
    cycle(); chk("basic_lat4_valid", out_valid, 1);
    chk("basic_value", out_h, 8'h01);
    cycle();

    // Seed and mask
    run_one(40'h0102030405, 8'hA5, 8'hFF, r);
    chk("seed_value", r, 8'hA4);
    run_one(40'h0102030405, 8'hA5, 8'h0F, r);
    chk("mask_value", r, 8'h04);

    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    chk("clr_idle", hcnt, 0);

    // Back-to-back keys
    got.delete(); exp_q.delete(); n = 0; first = -1; last = -1;
    for (int it = 0; it < 30 && got.size() < 8; it++) begin
      prev = got.size();
      if (n < 8) begin
        in_valid = 1'b1; in_key = keys[n]; seed = 8'(n * 19); mask = 8'hFF ^ 8'(n);
      end else begin
        in_valid = 1'b0; in_key = 40'hCAFECAFECA;
      end
      cycle();
      if (acc) begin
        exp_q.push_back(model(in_key, seed, mask));
        n++;
      end
      if (got.size() > prev) begin
        if (first < 0) first = it;
        last = it;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", got.size(), 8);
    chk("b2b_consecutive", last - first, 7);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("b2b_value", got[i], exp_q[i]);
    chk("b2b_hash_cnt", hcnt, 8);

    // Stall with a full pipeline
    out_ready = 1'b0; got.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_key = keys[7-i]; seed = 8'h3C; mask = 8'hF0 | 8'(i);
      cycle();
      chk("stall_fill_acc", acc, 1);
      exp_q.push_back(model(in_key, seed, mask));
    end
    chk("stall_full_valid", out_valid, 1);
    in_valid = 1'b1; in_key = 40'h1122334455; seed = 8'h00; mask = 8'hFF;
    k4exp = model(in_key, seed, mask);
    hold = out_h;
    chk("stall_head", hold, exp_q[0]);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_no_accept", acc, 0);
      chk("stall_hold", {in_ready, out_valid, out_h}, {1'b0, 1'b1, hold});
    end
    out_ready = 1'b1;
    for (int it = 0; it < 20 && got.size() < 5; it++) begin
      cycle();
      if (acc && in_valid) begin
        exp_q.push_back(k4exp);
        in_valid = 1'b0; in_key = 40'hFFFFFFFFFF;
      end
    end
    for (int i = 0; i < 4; i++) cycle();
    chk("stall_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("stall_value", got[i], exp_q[i]);
    chk("stall_hash_cnt", hcnt, 13);

    // Reset with three keys in flight
    got.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_key = keys[i]; seed = 8'h00; mask = 8'hFF;
      cycle();
    end
    in_valid = 1'b0;
    chk("inflight_not_out", out_valid, 0);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_hash_cnt", hcnt, 0);
    for (int i = 0; i < 6; i++) cycle();
    chk("midrst_none_emitted", got.size(), 0);
    chk("midrst_still_idle", out_valid, 0);

    // cnt_clr together with a delivery
    got.delete();
    in_valid = 1'b1; in_key = keys[3]; cycle();
    in_key = keys[4]; cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && got.size() < 1; i++) cycle();
    chk("clr_pre_cnt", hcnt, 1);
    chk("clr_pre_valid", out_valid, 1);
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    chk("clr_delivered", got.size(), 2);
    chk("clr_priority", hcnt, 0);

    // Generic 20:8 ratio, LAT=3, 2-bit saturating counter
    chk("g_in_ready", g_in_ready, 1);
    g_in_valid = 1'b1; g_key = 20'hABCDE;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      if (c == 2) chk("g_lat2", g_out_valid, 0);
      if (c == 3) begin
        chk("g_lat3_valid", g_out_valid, 1);
        chk("g_value", g_out_h, 8'h68);
      end
      if (c == 5) chk("g_cnt_2", g_cnt, 2);
    end
    g_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("g_cnt_sat", g_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
